// File: rtl/port_scheduler.sv
// port_scheduler: shares one SRAM write path among num_of_ports ingress ports.
// Each decision picks a winner by strict priority or by weighted round-robin.
// The winner is presented on a valid/ready handshake and is held until accepted.
module port_scheduler #(
    parameter int num_of_ports = 16,
    parameter int weight_width = 4,
    localparam int id_width    = $clog2(num_of_ports)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 sp0_wrr1,
    input  logic [num_of_ports-1:0]              req,
    input  logic [num_of_ports*weight_width-1:0] weight_cfg,
    output logic                                 grant_valid,
    input  logic                                 grant_ready,
    output logic [num_of_ports-1:0]              grant_onehot,
    output logic [id_width-1:0]                  grant_id
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                  state, state_nxt;
    logic [id_width-1:0]     ptr;            // WRR pointer: last port that won in WRR
    logic [weight_width-1:0] credit;         // grants left for ptr before the search moves on
    logic                    pend_wrr;       // pending grant was a WRR decision
    logic [weight_width-1:0] pend_credit;    // credit to install when the grant is accepted

    logic [weight_width-1:0] weight_arr [num_of_ports];
    logic [id_width-1:0]     sp_id, wrr_id, dec_id;
    logic                    sp_found, wrr_found;
    logic [weight_width-1:0] wrr_w, wrr_credit_nxt;
    logic                    accept;

    assign accept = grant_valid && grant_ready;

    // Unpack the flat weight bus into one entry per port.
    always_comb begin
        for (int i = 0; i < num_of_ports; i++) begin
            weight_arr[i] = weight_cfg[i*weight_width +: weight_width];
        end
    end

    // Strict priority: lowest-index requester wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sp_found = 1'b0;
        sp_id    = '0;
        for (int i = 0; i < num_of_ports; i++) begin
            if (!sp_found && req[id_width'(i)]) begin
                sp_found = 1'b1;
                sp_id    = id_width'(i);
            end
        end
    end

    // WRR: stay on ptr while it has credit, else search ptr+1 .. ptr (wrapping).
    always_comb begin
        wrr_found = 1'b0;
        wrr_id    = ptr;
        if (req[ptr] && credit != '0) begin
            wrr_found = 1'b1;
        end else begin
            for (int i = 1; i <= num_of_ports; i++) begin
                if (!wrr_found && req[id_width'((int'(ptr) + i) % num_of_ports)]) begin
                    wrr_found = 1'b1;
                    wrr_id    = id_width'((int'(ptr) + i) % num_of_ports);
                end
            end
        end
    end

    // Credit to commit if this WRR decision is accepted; zero weight counts as one.
    always_comb begin
        wrr_w = weight_arr[wrr_id];
        if (wrr_id == ptr && credit != '0) begin
            wrr_credit_nxt = credit - weight_width'(1);
        end else begin
            wrr_credit_nxt = (wrr_w == '0) ? '0 : wrr_w - weight_width'(1);
        end
        dec_id = sp0_wrr1 ? wrr_id : sp_id;
    end

    // Next-state logic for the IDLE/GRANT handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req != '0) state_nxt = GRANT;
            GRANT:   if (accept)    state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Register the grant at decision time; commit WRR state only on acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_valid  <= 1'b0;
            grant_onehot <= '0;
            grant_id     <= '0;
            pend_wrr     <= 1'b0;
            pend_credit  <= '0;
            ptr          <= id_width'(num_of_ports - 1);
            credit       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != '0) begin
                        grant_valid  <= 1'b1;
                        grant_id     <= dec_id;
                        grant_onehot <= num_of_ports'(1) << dec_id;
                        pend_wrr     <= sp0_wrr1;
                        pend_credit  <= wrr_credit_nxt;
                    end
                end
                GRANT: begin
                    if (accept) begin
                        grant_valid  <= 1'b0;
                        grant_onehot <= '0;
                        grant_id     <= '0;
                        if (pend_wrr) begin
                            ptr    <= grant_id;
                            credit <= pend_credit;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
